// File: rtl/sprite_line_fetcher_if.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_line_fetcher_if
//  Description : Request, VRAM read-port and pixel-stream signal bundle for
//                the sprite line fetcher.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sprite_line_fetcher_if;
  // Request channel
  logic         req_valid;
  logic         req_ready;
  logic [7:0]   req_sprite;
  logic [3:0]   req_row;
  logic [9:0]   req_x;
  logic         req_hflip;
  // VRAM read port
  logic [11:0]  vram_read_addr;
  logic [127:0] vram_read_data;
  // Pixel stream
  logic         pix_valid;
  logic         pix_ready;
  logic [7:0]   pix_data;
  logic         pix_opaque;
  logic [9:0]   pix_x;
  logic         pix_last;
  // Status
  logic         idle;

  // Fetcher side
  modport slave (
    input  req_valid, req_sprite, req_row, req_x, req_hflip,
    output req_ready,
    output vram_read_addr,
    input  vram_read_data,
    output pix_valid, pix_data, pix_opaque, pix_x, pix_last,
    input  pix_ready,
    output idle
  );

  // Requester / VRAM / compositor side
  modport master (
    output req_valid, req_sprite, req_row, req_x, req_hflip,
    input  req_ready,
    input  vram_read_addr,
    output vram_read_data,
    input  pix_valid, pix_data, pix_opaque, pix_x, pix_last,
    output pix_ready,
    input  idle
  );
endinterface
`default_nettype wire

// File: rtl/sprite_line_fetcher.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_line_fetcher
//  Description : Fetches 16-pixel sprite lines from sprite VRAM and serialises
//                them into a pixel stream. A one-line stage buffer prefetches
//                the next line while the active one drains.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_line_fetcher (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             flush,
  sprite_line_fetcher_if.slave  bus
);

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_ADDR = 2'd1,
    F_CAP  = 2'd2
  } fetch_e;

  fetch_e         fetch_q, fetch_d;
  logic [11:0]    addr_q, addr_d;
  logic [9:0]     pend_x_q, pend_x_d;
  logic           pend_hflip_q, pend_hflip_d;

  logic           act_valid_q, act_valid_d;
  logic [127:0]   act_line_q, act_line_d;
  logic [9:0]     act_x_q, act_x_d;
  logic           act_hflip_q, act_hflip_d;
  logic [3:0]     act_k_q, act_k_d;

  logic           stg_valid_q, stg_valid_d;
  logic [127:0]   stg_line_q, stg_line_d;
  logic [9:0]     stg_x_q, stg_x_d;
  logic           stg_hflip_q, stg_hflip_d;

  logic [7:0]     pix_data_q, pix_data_d;
  logic [9:0]     pix_x_q, pix_x_d;
  logic           pix_last_q, pix_last_d;

  logic           req_ready_w;
  logic           accept_w;
  logic           pix_hs_w;
  logic           act_done_w;
  logic [3:0]     sel_w;

  // Ready only when nothing is in flight and there is room for the result
  assign req_ready_w = (fetch_q == F_IDLE) && !stg_valid_q && !flush && reset_n;
  assign accept_w    = bus.req_valid && req_ready_w;
  assign pix_hs_w    = act_valid_q && bus.pix_ready;
  assign act_done_w  = pix_hs_w && (act_k_q == 4'hF);

  // Next-state: fetch FSM, active/stage line movement, registered pixel outputs
  always_comb begin
    fetch_d      = fetch_q;
    addr_d       = addr_q;
    pend_x_d     = pend_x_q;
    pend_hflip_d = pend_hflip_q;
    act_valid_d  = act_valid_q;
    act_line_d   = act_line_q;
    act_x_d      = act_x_q;
    act_hflip_d  = act_hflip_q;
    act_k_d      = act_k_q;
    stg_valid_d  = stg_valid_q;
    stg_line_d   = stg_line_q;
    stg_x_d      = stg_x_q;
    stg_hflip_d  = stg_hflip_q;
    sel_w        = 4'd0;
    pix_data_d   = 8'd0;
    pix_x_d      = 10'd0;
    pix_last_d   = 1'b0;

    case (fetch_q)
      F_IDLE: begin
        if (accept_w) begin
          fetch_d      = F_ADDR;
          addr_d       = {bus.req_sprite, bus.req_row};
          pend_x_d     = bus.req_x;
          pend_hflip_d = bus.req_hflip;
        end
      end
      F_ADDR:  fetch_d = F_CAP;
      F_CAP:   fetch_d = F_IDLE;
      default: fetch_d = F_IDLE;
    endcase

    // Pixel consumed: advance, or retire the line and pull in the staged one
    if (pix_hs_w) begin
      if (act_done_w) begin
        if (stg_valid_q) begin
          act_valid_d = 1'b1;
          act_line_d  = stg_line_q;
          act_x_d     = stg_x_q;
          act_hflip_d = stg_hflip_q;
          act_k_d     = 4'd0;
          stg_valid_d = 1'b0;
        end else begin
          act_valid_d = 1'b0;
        end
      end else begin
        act_k_d = act_k_q + 4'd1;
      end
    end

    // Captured line goes straight to active when active is (becoming) free;
    // a full stage never coexists with a capture since it blocks new fetches
    if (fetch_q == F_CAP) begin
      if (!act_valid_q || (act_done_w && !stg_valid_q)) begin
        act_valid_d = 1'b1;
        act_line_d  = bus.vram_read_data;
        act_x_d     = pend_x_q;
        act_hflip_d = pend_hflip_q;
        act_k_d     = 4'd0;
      end else begin
        stg_valid_d = 1'b1;
        stg_line_d  = bus.vram_read_data;
        stg_x_d     = pend_x_q;
        stg_hflip_d = pend_hflip_q;
      end
    end

    // Flush drops every line and any fetch in flight; address is left alone
    if (flush) begin
      fetch_d     = F_IDLE;
      act_valid_d = 1'b0;
      stg_valid_d = 1'b0;
    end

    // Pixel outputs are registered from the next active state; 15-k == ~k
    sel_w = act_hflip_d ? ~act_k_d : act_k_d;
    if (act_valid_d) begin
      pix_data_d = act_line_d[{sel_w, 3'b000} +: 8];
      pix_x_d    = act_x_d + {6'd0, act_k_d};
      pix_last_d = (act_k_d == 4'hF);
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_q      <= F_IDLE;
      addr_q       <= 12'd0;
      pend_x_q     <= 10'd0;
      pend_hflip_q <= 1'b0;
      act_valid_q  <= 1'b0;
      act_line_q   <= 128'd0;
      act_x_q      <= 10'd0;
      act_hflip_q  <= 1'b0;
      act_k_q      <= 4'd0;
      stg_valid_q  <= 1'b0;
      stg_line_q   <= 128'd0;
      stg_x_q      <= 10'd0;
      stg_hflip_q  <= 1'b0;
      pix_data_q   <= 8'd0;
      pix_x_q      <= 10'd0;
      pix_last_q   <= 1'b0;
    end else begin
      fetch_q      <= fetch_d;
      addr_q       <= addr_d;
      pend_x_q     <= pend_x_d;
      pend_hflip_q <= pend_hflip_d;
      act_valid_q  <= act_valid_d;
      act_line_q   <= act_line_d;
      act_x_q      <= act_x_d;
      act_hflip_q  <= act_hflip_d;
      act_k_q      <= act_k_d;
      stg_valid_q  <= stg_valid_d;
      stg_line_q   <= stg_line_d;
      stg_x_q      <= stg_x_d;
      stg_hflip_q  <= stg_hflip_d;
      pix_data_q   <= pix_data_d;
      pix_x_q      <= pix_x_d;
      pix_last_q   <= pix_last_d;
    end
  end

  assign bus.req_ready      = req_ready_w;
  assign bus.vram_read_addr = addr_q;
  assign bus.pix_valid      = act_valid_q;
  assign bus.pix_data       = pix_data_q;
  assign bus.pix_opaque     = |pix_data_q;
  assign bus.pix_x          = pix_x_q;
  assign bus.pix_last       = pix_last_q;
  assign bus.idle           = !act_valid_q && !stg_valid_q && (fetch_q == F_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_fetcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_line_fetcher
//  Description : Directed self-checking bench for sprite_line_fetcher with a
//                VRAM model and a pixel scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_line_fetcher;

  logic clk = 1'b0;
  logic reset_n;
  logic flush;
  int   n_checks = 0;
  int   n_fail   = 0;

  sprite_line_fetcher_if vif();

  sprite_line_fetcher dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (vif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [9:0] x;
    logic       last;
  } pix_t;

  pix_t exp_q[$];
  int   hs_cnt = 0;
  int   cyc = 0;
  int   hs_cyc [512];
  int   ready_mode = 0;

  // Line content: addr 0x123 holds k+1, addr 0x055 starts 0,0,5
  function automatic logic [7:0] gen_pix(input logic [11:0] a, input int k);
    logic [7:0] kb;
    kb = 8'(k);
    if (a == 12'h123) return kb + 8'd1;
    if (a == 12'h055) begin
      if (k < 2) return 8'd0;
      if (k == 2) return 8'd5;
      return 8'h40 + kb;
    end
    return (a[7:0] + 8'd13 * kb) ^ 8'h5A;
  endfunction

  function automatic logic [127:0] line_of(input logic [11:0] a);
    logic [127:0] l;
    l = '0;
    for (int k = 0; k < 16; k++) l[8*k +: 8] = gen_pix(a, k);
    return l;
  endfunction

  // VRAM: one-cycle registered read
  always @(posedge clk) vif.vram_read_data <= line_of(vif.vram_read_addr);

  // Downstream ready: 0 = always, 1 = random 50%, else never
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       vif.pix_ready = 1'b1;
      1:       vif.pix_ready = 1'($urandom_range(0, 1));
      default: vif.pix_ready = 1'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_line(input logic [11:0] a, input logic [9:0] x, input logic hf, input int n);
    pix_t e;
    for (int k = 0; k < n; k++) begin
      e.d    = gen_pix(a, hf ? 15 - k : k);
      e.x    = x + 10'(k);
      e.last = (k == 15);
      exp_q.push_back(e);
    end
  endtask

  // Present a request and hold it until accepted; returns cycles spent not ready
  task automatic send_req(input logic [11:0] a, input logic [9:0] x, input logic hf, output int waits);
    logic acc;
    logic r;
    acc   = 1'b0;
    waits = 0;
    vif.req_sprite = a[11:4];
    vif.req_row    = a[3:0];
    vif.req_x      = x;
    vif.req_hflip  = hf;
    vif.req_valid  = 1'b1;
    for (int i = 0; i < 400 && !acc; i++) begin
      @(negedge clk);
      r = vif.req_ready;
      @(posedge clk);
      #1;
      if (r) acc = 1'b1;
      else   waits++;
    end
    vif.req_valid = 1'b0;
    chk("req_accept", 32'(acc), 1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int i;
    i = 0;
    while (!(exp_q.size() == 0 && vif.idle === 1'b1) && i < budget) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk(tag, 32'(exp_q.size() == 0 && vif.idle === 1'b1), 1);
    exp_q.delete();
  endtask

  task automatic poll_hs(input int target, input int budget);
    int i;
    i = 0;
    while (hs_cnt != target && i < budget) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("hs_reach", hs_cnt, target);
  endtask

  // Pixel monitor: scoreboard compare on handshake, hold check while stalled
  logic       prev_stall = 1'b0;
  logic       prev_ok    = 1'b0;
  logic [7:0] prev_d;
  logic [9:0] prev_x;
  logic       prev_last;
  logic       prev_valid;

  always @(negedge clk) begin
    pix_t e;
    logic hs;
    cyc <= cyc + 1;
    if (prev_stall && prev_ok) begin
      chk("stall_valid", 32'(vif.pix_valid), 32'(prev_valid));
      chk("stall_data",  32'(vif.pix_data),  32'(prev_d));
      chk("stall_x",     32'(vif.pix_x),     32'(prev_x));
      chk("stall_last",  32'(vif.pix_last),  32'(prev_last));
    end
    hs = reset_n && !flush && vif.pix_valid && vif.pix_ready;
    if (hs) begin
      chk("pixel_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pix_data",   32'(vif.pix_data),   32'(e.d));
        chk("pix_x",      32'(vif.pix_x),      32'(e.x));
        chk("pix_last",   32'(vif.pix_last),   32'(e.last));
        chk("pix_opaque", 32'(vif.pix_opaque), 32'(e.d != 8'd0));
      end
      if (hs_cnt < 512) hs_cyc[hs_cnt] <= cyc;
      hs_cnt <= hs_cnt + 1;
    end
    prev_stall <= vif.pix_valid && !vif.pix_ready;
    prev_ok    <= reset_n && !flush;
    prev_d     <= vif.pix_data;
    prev_x     <= vif.pix_x;
    prev_last  <= vif.pix_last;
    prev_valid <= vif.pix_valid;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w0, w1, w2, base;
    reset_n        = 1'b0;
    flush          = 1'b0;
    vif.req_valid  = 1'b0;
    vif.req_sprite = 8'd0;
    vif.req_row    = 4'd0;
    vif.req_x      = 10'd0;
    vif.req_hflip  = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    chk("rst_req_ready",  32'(vif.req_ready), 0);
    chk("rst_pix_valid",  32'(vif.pix_valid), 0);
    chk("rst_pix_data",   32'(vif.pix_data), 0);
    chk("rst_pix_opaque", 32'(vif.pix_opaque), 0);
    chk("rst_pix_x",      32'(vif.pix_x), 0);
    chk("rst_pix_last",   32'(vif.pix_last), 0);
    chk("rst_idle",       32'(vif.idle), 1);
    chk("rst_addr",       32'(vif.vram_read_addr), 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 32'(vif.req_ready), 1);

    // Single request with latency checks
    push_line(12'h123, 10'd100, 1'b0, 16);
    send_req(12'h123, 10'd100, 1'b0, w0);
    chk("t1_addr", 32'(vif.vram_read_addr), 32'h123);
    chk("t1_valid_e0", 32'(vif.pix_valid), 0);
    @(posedge clk); #1;
    chk("t1_valid_e1", 32'(vif.pix_valid), 0);
    @(posedge clk); #1;
    chk("t1_valid_e2", 32'(vif.pix_valid), 1);
    chk("t1_first_data", 32'(vif.pix_data), 1);
    chk("t1_first_x", 32'(vif.pix_x), 100);
    chk("t1_first_last", 32'(vif.pix_last), 0);
    wait_drain("t1_drain", 100);

    // Horizontal flip, then transparent pixels
    push_line(12'h123, 10'd100, 1'b1, 16);
    send_req(12'h123, 10'd100, 1'b1, w0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t2_flip_first", 32'(vif.pix_data), 16);
    wait_drain("t2_drain", 100);
    push_line(12'h055, 10'd200, 1'b0, 16);
    send_req(12'h055, 10'd200, 1'b0, w0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t2_transparent", 32'(vif.pix_opaque), 0);
    wait_drain("t2b_drain", 100);

    // Back-to-back: three lines, no bubble, stage full stalls the third
    base = hs_cnt;
    push_line(12'h200, 10'd300, 1'b0, 16);
    push_line(12'h201, 10'd316, 1'b1, 16);
    push_line(12'h3A7, 10'd332, 1'b0, 16);
    send_req(12'h200, 10'd300, 1'b0, w0);
    send_req(12'h201, 10'd316, 1'b1, w1);
    send_req(12'h3A7, 10'd332, 1'b0, w2);
    chk("t3_wait_first", w0, 0);
    chk("t3_wait_second", w1, 2);
    chk("t3_wait_stage_full", w2, 15);
    wait_drain("t3_drain", 200);
    chk("t3_count", hs_cnt - base, 48);
    chk("t3_no_gap", hs_cyc[base + 47] - hs_cyc[base], 47);

    // Random backpressure over 8 lines
    base = hs_cnt;
    ready_mode = 1;
    for (int i = 0; i < 8; i++) begin
      push_line(12'h300 + 12'(i * 17), 10'(i * 37), 1'(i), 16);
      send_req(12'h300 + 12'(i * 17), 10'(i * 37), 1'(i), w0);
    end
    wait_drain("t4_drain", 2000);
    chk("t4_count", hs_cnt - base, 128);
    ready_mode = 0;
    @(posedge clk); #1;

    // X wrap
    push_line(12'h0AB, 10'd1016, 1'b0, 16);
    send_req(12'h0AB, 10'd1016, 1'b0, w0);
    wait_drain("t5_drain", 100);

    // Flush one cycle after accept
    base = hs_cnt;
    send_req(12'h111, 10'd50, 1'b0, w0);
    flush = 1'b1;
    chk("t6_flush_blocks_req", 32'(vif.req_ready), 0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("t6_idle_after_flush", 32'(vif.idle), 1);
    chk("t6_addr_holds", 32'(vif.vram_read_addr), 32'h111);
    repeat (6) @(posedge clk);
    #1;
    chk("t6_no_pixel_valid", 32'(vif.pix_valid), 0);
    chk("t6_no_pixels", hs_cnt - base, 0);

    // Flush with active at k=7 and stage full
    base = hs_cnt;
    push_line(12'h222, 10'd10, 1'b0, 7);
    send_req(12'h222, 10'd10, 1'b0, w0);
    send_req(12'h333, 10'd40, 1'b1, w1);
    poll_hs(base + 7, 100);
    chk("t6b_stage_full", 32'(vif.req_ready), 0);
    chk("t6b_k7_x", 32'(vif.pix_x), 17);
    chk("t6b_k7_valid", 32'(vif.pix_valid), 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("t6b_valid_cleared", 32'(vif.pix_valid), 0);
    chk("t6b_idle", 32'(vif.idle), 1);
    chk("t6b_expected_left", exp_q.size(), 0);
    exp_q.delete();

    // Reset mid-stream
    base = hs_cnt;
    push_line(12'h0F0, 10'd500, 1'b0, 3);
    send_req(12'h0F0, 10'd500, 1'b0, w0);
    send_req(12'h0F1, 10'd600, 1'b0, w1);
    poll_hs(base + 3, 100);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("t6c_pix_valid",  32'(vif.pix_valid), 0);
    chk("t6c_pix_data",   32'(vif.pix_data), 0);
    chk("t6c_pix_opaque", 32'(vif.pix_opaque), 0);
    chk("t6c_pix_x",      32'(vif.pix_x), 0);
    chk("t6c_pix_last",   32'(vif.pix_last), 0);
    chk("t6c_idle",       32'(vif.idle), 1);
    chk("t6c_addr",       32'(vif.vram_read_addr), 0);
    chk("t6c_req_ready",  32'(vif.req_ready), 0);
    chk("t6c_expected_left", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("t6c_ready_after", 32'(vif.req_ready), 1);

    // Operation resumes after reset, flipped line wrapping at 1023
    push_line(12'h123, 10'd1020, 1'b1, 16);
    send_req(12'h123, 10'd1020, 1'b1, w0);
    wait_drain("t7_drain", 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
